// File: rtl/field_counter.sv
// field_counter: register-field counter/statistics cell.
// It holds an F_WIDTH value. Software ports write it. Hardware events
// increment or decrement it. The counter saturates or wraps, and it can clear
// on read. Overflow and underflow flags are sticky. thresh_hit pulses on an
// upward crossing of THRESH.
//
// Ports:
//   clk          clock; all state changes on posedge
//   rst_n        synchronous active-low reset
//   sw_wr        per-port software write strobe (lowest asserted index wins)
//   sw_rd        per-port software read strobe
//   sw_wr_data   write data, port i at [i*F_WIDTH +: F_WIDTH]
//   cnt_en       gates hw_inc / hw_dec (not hw_clr)
//   hw_inc       add hw_inc_amt this cycle
//   hw_inc_amt   unsigned increment amount
//   hw_dec       subtract 1 this cycle
//   hw_clr       hardware clear, highest priority
//   field_value  registered counter value
//   ovf, udf     sticky overflow / underflow flags
//   thresh_hit   one-cycle pulse when field_value first reaches >= THRESH
module field_counter #(
  parameter int unsigned F_WIDTH     = 8,
  parameter int unsigned SW_CNT      = 1,
  parameter int unsigned INC_WIDTH   = 1,
  parameter int unsigned SATURATE    = 1,
  parameter int unsigned CLR_ON_RD   = 0,
  parameter int unsigned WR_PRIORITY = 0,
  parameter logic [F_WIDTH-1:0] THRESH    = '1,
  parameter logic [F_WIDTH-1:0] RST_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SW_CNT-1:0]           sw_wr,
  input  logic [SW_CNT-1:0]           sw_rd,
  input  logic [F_WIDTH*SW_CNT-1:0]   sw_wr_data,
  input  logic                        cnt_en,
  input  logic                        hw_inc,
  input  logic [INC_WIDTH-1:0]        hw_inc_amt,
  input  logic                        hw_dec,
  input  logic                        hw_clr,
  output logic [F_WIDTH-1:0]          field_value,
  output logic                        ovf,
  output logic                        udf,
  output logic                        thresh_hit
);

  // Two extra bits: bit F_WIDTH flags overflow and the MSB flags a negative sum.
  localparam int unsigned SW = F_WIDTH + 2;

  logic               wr_any;
  logic [F_WIDTH-1:0] wr_data;
  logic               rd_any;
  logic [SW-1:0]      inc_term;
  logic [SW-1:0]      dec_term;
  logic [SW-1:0]      delta;
  logic [SW-1:0]      base;
  logic [SW-1:0]      sum;
  logic               use_sum;
  logic [F_WIDTH-1:0] nxt;
  logic               set_ovf;
  logic               set_udf;
  logic               clr_flags;

  // Lowest-index asserted write port wins.
  always_comb begin
    wr_any  = 1'b0;
    wr_data = '0;
    for (int unsigned i = 0; i < SW_CNT; i++) begin
      if (sw_wr[i] && !wr_any) begin
        wr_any  = 1'b1;
        wr_data = sw_wr_data[i*F_WIDTH +: F_WIDTH];
      end
    end
  end

  assign rd_any = |sw_rd;

  // The delta is a two's-complement value in SW bits. inc and dec together give amt-1.
  assign inc_term = (cnt_en && hw_inc) ? {{(SW-INC_WIDTH){1'b0}}, hw_inc_amt} : '0;
  assign dec_term = (cnt_en && hw_dec) ? SW'(1) : '0;
  assign delta    = inc_term - dec_term;

  always_comb begin
    use_sum = 1'b0;
    base    = '0;
    sum     = '0;
    nxt     = field_value;
    set_ovf = 1'b0;
    set_udf = 1'b0;

    if (hw_clr) begin
      nxt = '0;
    end else if (wr_any) begin
      if ((WR_PRIORITY != 0) && (|delta)) begin
        base    = {2'b00, field_value};
        use_sum = 1'b1;
      end else begin
        nxt = wr_data;
      end
    end else if ((CLR_ON_RD != 0) && rd_any) begin
      // Clear-on-read still applies this cycle's count, so no event is lost.
      base    = '0;
      use_sum = 1'b1;
    end else begin
      base    = {2'b00, field_value};
      use_sum = 1'b1;
    end

    if (use_sum) begin
      sum = base + delta;
      if (sum[SW-1]) begin
        set_udf = 1'b1;
        nxt     = (SATURATE != 0) ? '0 : '1;
      end else if (sum[F_WIDTH]) begin
        set_ovf = 1'b1;
        nxt     = (SATURATE != 0) ? '1 : sum[F_WIDTH-1:0];
      end else begin
        nxt = sum[F_WIDTH-1:0];
      end
    end

    clr_flags = !hw_clr && (wr_any || ((CLR_ON_RD != 0) && rd_any));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      field_value <= RST_VALUE;
      ovf         <= 1'b0;
      udf         <= 1'b0;
      thresh_hit  <= 1'b0;
    end else begin
      field_value <= nxt;
      // A flag set in this cycle takes priority over a flag clear in the same cycle.
      ovf         <= set_ovf || (ovf && !clr_flags);
      udf         <= set_udf || (udf && !clr_flags);
      thresh_hit  <= (nxt >= THRESH) && (field_value < THRESH);
    end
  end

endmodule

// File: tb/tb_field_counter.sv
// Bench for field_counter. Four instances with different configurations
// (F_WIDTH=4, INC_WIDTH=2, THRESH=12) receive the same stimulus. A per-instance
// integer reference model predicts every output.
module tb_field_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] sw_wr;
  logic [1:0] sw_rd;
  logic [7:0] sw_wr_data;
  logic       cnt_en;
  logic       hw_inc;
  logic [1:0] hw_inc_amt;
  logic       hw_dec;
  logic       hw_clr;

  logic [3:0] fv  [4];
  logic       ovf [4];
  logic       udf [4];
  logic       th  [4];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state per instance.
  int mv [4];
  bit mo [4];
  bit mu [4];
  bit mt [4];

  // Instance configurations: saturate, clear-on-read, write priority, ports, reset value.
  function automatic bit cfg_sat(input int i);   return (i == 0 || i == 3); endfunction
  function automatic bit cfg_clrrd(input int i); return (i == 2 || i == 3); endfunction
  function automatic bit cfg_wp(input int i);    return (i == 1 || i == 3); endfunction
  function automatic int cfg_swc(input int i);   return (i == 1 || i == 2) ? 2 : 1; endfunction
  function automatic int cfg_rst(input int i);
    case (i)
      1:       return 5;
      2:       return 13;
      default: return 0;
    endcase
  endfunction

  field_counter #(.F_WIDTH(4), .SW_CNT(1), .INC_WIDTH(2), .SATURATE(1), .CLR_ON_RD(0),
                  .WR_PRIORITY(0), .THRESH(4'd12), .RST_VALUE(4'd0)) u0 (
    .clk(clk), .rst_n(rst_n), .sw_wr(sw_wr[0:0]), .sw_rd(sw_rd[0:0]),
    .sw_wr_data(sw_wr_data[3:0]), .cnt_en(cnt_en), .hw_inc(hw_inc),
    .hw_inc_amt(hw_inc_amt), .hw_dec(hw_dec), .hw_clr(hw_clr),
    .field_value(fv[0]), .ovf(ovf[0]), .udf(udf[0]), .thresh_hit(th[0]));

  field_counter #(.F_WIDTH(4), .SW_CNT(2), .INC_WIDTH(2), .SATURATE(0), .CLR_ON_RD(0),
                  .WR_PRIORITY(1), .THRESH(4'd12), .RST_VALUE(4'd5)) u1 (
    .clk(clk), .rst_n(rst_n), .sw_wr(sw_wr), .sw_rd(sw_rd),
    .sw_wr_data(sw_wr_data), .cnt_en(cnt_en), .hw_inc(hw_inc),
    .hw_inc_amt(hw_inc_amt), .hw_dec(hw_dec), .hw_clr(hw_clr),
    .field_value(fv[1]), .ovf(ovf[1]), .udf(udf[1]), .thresh_hit(th[1]));

  field_counter #(.F_WIDTH(4), .SW_CNT(2), .INC_WIDTH(2), .SATURATE(0), .CLR_ON_RD(1),
                  .WR_PRIORITY(0), .THRESH(4'd12), .RST_VALUE(4'd13)) u2 (
    .clk(clk), .rst_n(rst_n), .sw_wr(sw_wr), .sw_rd(sw_rd),
    .sw_wr_data(sw_wr_data), .cnt_en(cnt_en), .hw_inc(hw_inc),
    .hw_inc_amt(hw_inc_amt), .hw_dec(hw_dec), .hw_clr(hw_clr),
    .field_value(fv[2]), .ovf(ovf[2]), .udf(udf[2]), .thresh_hit(th[2]));

  field_counter #(.F_WIDTH(4), .SW_CNT(1), .INC_WIDTH(2), .SATURATE(1), .CLR_ON_RD(1),
                  .WR_PRIORITY(1), .THRESH(4'd12), .RST_VALUE(4'd0)) u3 (
    .clk(clk), .rst_n(rst_n), .sw_wr(sw_wr[0:0]), .sw_rd(sw_rd[0:0]),
    .sw_wr_data(sw_wr_data[3:0]), .cnt_en(cnt_en), .hw_inc(hw_inc),
    .hw_inc_amt(hw_inc_amt), .hw_dec(hw_dec), .hw_clr(hw_clr),
    .field_value(fv[3]), .ovf(ovf[3]), .udf(udf[3]), .thresh_hit(th[3]));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Next state from the current inputs, using integer arithmetic and the priority list.
  task automatic model_step(input int i);
    int  d, sum, nv, wd;
    bit  wr_any, rd_any, use_sum, so, su, clr;
    if (!rst_n) begin
      mv[i] = cfg_rst(i); mo[i] = 0; mu[i] = 0; mt[i] = 0;
      return;
    end
    d = ((cnt_en && hw_inc) ? int'(hw_inc_amt) : 0) - ((cnt_en && hw_dec) ? 1 : 0);
    wr_any = 0; wd = 0;
    if (sw_wr[0]) begin
      wr_any = 1; wd = int'(sw_wr_data[3:0]);
    end else if (cfg_swc(i) == 2 && sw_wr[1]) begin
      wr_any = 1; wd = int'(sw_wr_data[7:4]);
    end
    rd_any = (cfg_swc(i) == 2) ? (sw_rd != 2'b00) : sw_rd[0];
    use_sum = 0; sum = 0; nv = 0; so = 0; su = 0;
    if (hw_clr)                      nv = 0;
    else if (wr_any) begin
      if (cfg_wp(i) && d != 0) begin sum = mv[i] + d; use_sum = 1; end
      else nv = wd;
    end
    else if (cfg_clrrd(i) && rd_any) begin sum = d; use_sum = 1; end
    else begin sum = mv[i] + d; use_sum = 1; end
    if (use_sum) begin
      if (sum > 15)     begin so = 1; nv = cfg_sat(i) ? 15 : sum - 16; end
      else if (sum < 0) begin su = 1; nv = cfg_sat(i) ? 0 : 15; end
      else nv = sum;
    end
    clr = !hw_clr && (wr_any || (cfg_clrrd(i) && rd_any));
    mt[i] = (nv >= 12) && (mv[i] < 12);
    mo[i] = so || (mo[i] && !clr);
    mu[i] = su || (mu[i] && !clr);
    mv[i] = nv;
  endtask

  task automatic cyc(input bit r, input logic [1:0] wr, input logic [1:0] rd,
                     input logic [7:0] wd, input bit en, input bit inc,
                     input logic [1:0] amt, input bit dec, input bit clr);
    rst_n = r; sw_wr = wr; sw_rd = rd; sw_wr_data = wd;
    cnt_en = en; hw_inc = inc; hw_inc_amt = amt; hw_dec = dec; hw_clr = clr;
    for (int i = 0; i < 4; i++) model_step(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("u%0d value", i), 8'(fv[i]),  8'(mv[i]));
      check($sformatf("u%0d ovf", i),   8'(ovf[i]), 8'(mo[i]));
      check($sformatf("u%0d udf", i),   8'(udf[i]), 8'(mu[i]));
      check($sformatf("u%0d thresh", i), 8'(th[i]), 8'(mt[i]));
    end
  endtask

  // A software write with the same data on both ports.
  task automatic wr(input logic [3:0] v);
    cyc(1, 2'b01, 2'b00, {v, v}, 0, 0, 2'd0, 0, 0);
  endtask

  initial begin
    // Reset while inc is pulsing.
    cyc(0, 2'b00, 2'b00, 8'h00, 1, 1, 2'd3, 0, 0);
    cyc(0, 2'b00, 2'b00, 8'h00, 1, 1, 2'd3, 0, 0);
    // Saturate/wrap at the top, then the sticky flag clears on a write.
    wr(4'd14);
    cyc(1, 2'b00, 2'b00, 8'h00, 1, 1, 2'd3, 0, 0);
    cyc(1, 2'b00, 2'b00, 8'h00, 1, 1, 2'd3, 0, 0);
    wr(4'd5);
    // Underflow from zero.
    wr(4'd0);
    cyc(1, 2'b00, 2'b00, 8'h00, 1, 0, 2'd0, 1, 0);
    // Threshold crossing followed by a hold.
    wr(4'd10);
    cyc(1, 2'b00, 2'b00, 8'h00, 1, 1, 2'd2, 0, 0);
    cyc(1, 2'b00, 2'b00, 8'h00, 1, 0, 2'd0, 0, 0);
    // Write against count in the same cycle, then the same with hw_clr.
    wr(4'd3);
    cyc(1, 2'b01, 2'b00, 8'h77, 1, 1, 2'd1, 0, 0);
    wr(4'd3);
    cyc(1, 2'b01, 2'b00, 8'h77, 1, 1, 2'd1, 0, 1);
    // Clear-on-read together with an increment, then a two-port write.
    wr(4'd9);
    cyc(1, 2'b00, 2'b01, 8'h00, 1, 1, 2'd2, 0, 0);
    cyc(1, 2'b11, 2'b00, 8'h63, 0, 0, 2'd0, 0, 0);
    // cnt_en low must gate the count.
    cyc(1, 2'b00, 2'b00, 8'h00, 0, 1, 2'd3, 1, 0);

    for (int n = 0; n < 2000; n++) begin
      cyc(($urandom_range(63) != 0),
          ($urandom_range(5) == 0) ? 2'($urandom) : 2'b00,
          ($urandom_range(4) == 0) ? 2'($urandom) : 2'b00,
          8'($urandom),
          ($urandom_range(7) != 0),
          1'($urandom), 2'($urandom), 1'($urandom),
          ($urandom_range(15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
